// File: rtl/imem_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 16
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Stream source / memory side
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: parses a length header followed by
// 16-bit words from a byte stream and writes them to consecutive even
// addresses, holding the fetch pipeline until the load completes.
module imem_loader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  imem_loader_if.slave   bus,
  output logic           hold,
  output logic           done,
  output logic           overflow
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE
  } state_t;

  localparam logic [16:0] SLOT_LIMIT = 17'(MAX_WORDS);

  state_t            state;
  logic [15:0]       count;
  logic [15:0]       idx;
  logic [7:0]        hi_byte;
  logic              receiving;
  logic              slot_free;
  logic [15:0]       idx_next;
  logic [ADDR_W-1:0] slot_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Decode receive states, slot availability and the target address of the current word
  always_comb begin
    receiving = (state == LEN_HI) || (state == LEN_LO) ||
                (state == DATA_HI) || (state == DATA_LO);
    slot_free = {1'b0, idx} < SLOT_LIMIT;
    idx_next  = idx + 16'd1;
    slot_addr = BASE_ADDR + ADDR_W'({idx, 1'b0});
  end

  // abort masks in_ready so a byte offered alongside it is never consumed
  assign bus.in_ready = receiving && !abort;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;

  // Load sequencer with registered strobes, write bus and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      idx      <= '0;
      hi_byte  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      hold     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        hold  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= LEN_HI;
              hold     <= 1'b1;
              overflow <= 1'b0;
              idx      <= '0;
            end
          end
          LEN_HI: begin
            if (bus.in_valid) begin
              count[15:8] <= bus.in_data;
              state       <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (bus.in_valid) begin
              count[7:0] <= bus.in_data;
              if ({count[15:8], bus.in_data} == 16'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= DATA_HI;
              end
            end
          end
          DATA_HI: begin
            if (bus.in_valid) begin
              hi_byte <= bus.in_data;
              state   <= DATA_LO;
            end
          end
          // Strobe is issued on entry to WRITE so it is visible during the WRITE cycle
          DATA_LO: begin
            if (bus.in_valid) begin
              state <= WRITE;
              if (slot_free) begin
                wr_en   <= 1'b1;
                wr_addr <= slot_addr;
                wr_data <= {hi_byte, bus.in_data};
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          WRITE: begin
            idx <= idx_next;
            if (idx_next == count) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end
          DONE: begin
            state <= IDLE;
            hold  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            hold  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads
// compared against a word-list reference model of the expected writes.
module tb_imem_loader;

  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0000;
  localparam int          MAXW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic hold, done, overflow;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .bus     (bus),
    .hold    (hold),
    .done    (done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed activity, logged once per cycle away from the active edge
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  bit          hold_log[int];

  always @(negedge clk) begin
    hold_log[cyc] = hold;
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] words[$];
  int          s_cyc;
  int          wr_base;
  int          done_base;

  // Start a load of n words from 'words'; cut_at >= 0 stops before that byte with abort or reset
  task automatic run_load(input logic [15:0] n, input bit gaps, input int cut_at, input bit cut_rst);
    logic [7:0] bytes[$];
    int         guard;
    bit         acc;
    bytes = {};
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    wr_base   = wa_q.size();
    done_base = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
    check("overflow_cleared_by_start", 32'(overflow), 32'd0);
    check("hold_from_start_edge", 32'(hold), 32'd1);
    for (int b = 0; b < bytes.size(); b++) begin
      if (b == cut_at) begin
        if (cut_rst) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          #2;
          rst = 1'b1;
          #1;
          check("rst_async_in_ready", 32'(bus.in_ready), 32'd0);
          check("rst_async_wr_en", 32'(bus.wr_en), 32'd0);
          check("rst_async_wr_addr", 32'(bus.wr_addr), 32'd0);
          check("rst_async_wr_data", 32'(bus.wr_data), 32'd0);
          check("rst_async_hold", 32'(hold), 32'd0);
          check("rst_async_done", 32'(done), 32'd0);
          check("rst_async_overflow", 32'(overflow), 32'd0);
        end else begin
          @(negedge clk);
          bus.in_data  = bytes[b];
          bus.in_valid = 1'b1;
          abort        = 1'b1;
          #1;
          check("in_ready_masked_by_abort", 32'(bus.in_ready), 32'd0);
          @(posedge clk);
          #1;
          abort        = 1'b0;
          bus.in_valid = 1'b0;
          check("hold_low_after_abort", 32'(hold), 32'd0);
        end
        break;
      end
      guard = 0;
      do begin
        @(negedge clk);
        bus.in_data  = bytes[b];
        bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        check("byte_accept_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == done_base && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
  endtask

  // Reference: the first min(n, MAXW) words land at BASE + 2*i; done is sampled
  // high at the (3+3n)th edge after the start edge, i.e. in cycle s_cyc+2+3n
  task automatic verify_load(input logic [15:0] n, input bit gaps);
    int  exp_w;
    int  got_w;
    bit  ok;
    exp_w = (int'(n) < MAXW) ? int'(n) : MAXW;
    got_w = wa_q.size() - wr_base;
    check("done_pulse_count", 32'(done_cnt - done_base), 32'd1);
    check("write_count", 32'(got_w), 32'(exp_w));
    for (int i = 0; i < exp_w && i < got_w; i++) begin
      check("write_addr", 32'(wa_q[wr_base + i]), 32'(BASE + 16'(2 * i)));
      check("write_data", 32'(wd_q[wr_base + i]), 32'(words[i]));
      if (!gaps) check("write_cycle", 32'(wc_q[wr_base + i] - s_cyc), 32'(4 + 3 * i));
    end
    check("overflow_flag", 32'(overflow), 32'(int'(n) > MAXW));
    if (!gaps) check("done_latency", 32'(done_cyc - s_cyc), 32'(2 + 3 * int'(n)));
    ok = 1'b1;
    for (int c = s_cyc; c <= done_cyc; c++) if (!hold_log[c]) ok = 1'b0;
    check("hold_through_load", 32'(ok), 32'd1);
    check("hold_low_after_done", 32'(hold_log[done_cyc + 1]), 32'd0);
  endtask

  task automatic rand_words(input int n);
    words = {};
    for (int i = 0; i < n; i++) words.push_back(16'($urandom) | 16'h0101);
  endtask

  initial begin
    int base_w;
    bit ok;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_wr_en", 32'(bus.wr_en), 32'd0);
    check("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("reset_wr_data", 32'(bus.wr_data), 32'd0);
    check("reset_hold", 32'(hold), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed three-word program with continuous valid
    words = {16'hD104, 16'hA212, 16'h9412};
    run_load(16'd3, 1'b0, -1, 1'b0);
    wait_done(60);
    verify_load(16'd3, 1'b0);

    // Empty program
    run_load(16'd0, 1'b0, -1, 1'b0);
    wait_done(20);
    verify_load(16'd0, 1'b0);

    // Same program with random valid gaps
    run_load(16'd3, 1'b1, -1, 1'b0);
    wait_done(3000);
    verify_load(16'd3, 1'b1);

    // Random programs that fit, back to back
    for (int t = 0; t < 3; t++) begin
      rand_words(1 + t + 1);
      run_load(16'(words.size()), 1'b0, -1, 1'b0);
      wait_done(60);
      verify_load(16'(words.size()), 1'b0);
    end

    // Program longer than memory: extra words dropped, overflow set
    rand_words(6);
    run_load(16'd6, 1'b0, -1, 1'b0);
    wait_done(60);
    verify_load(16'd6, 1'b0);

    // Abort after the high byte of the second word
    rand_words(3);
    run_load(16'd3, 1'b0, 5, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    check("abort_write_count", 32'(wa_q.size() - wr_base), 32'd1);
    check("abort_first_addr", 32'(wa_q[wr_base]), 32'(BASE));
    check("abort_first_data", 32'(wd_q[wr_base]), 32'(words[0]));
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);

    // Fresh single-word load after abort starts again at the base address
    rand_words(1);
    run_load(16'd1, 1'b0, -1, 1'b0);
    wait_done(30);
    verify_load(16'd1, 1'b0);

    // Asynchronous reset in the middle of a load, then idle
    rand_words(3);
    run_load(16'd3, 1'b0, 6, 1'b1);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    base_w = wa_q.size();
    @(posedge clk);
    #1;
    s_cyc = cyc;
    repeat (5) @(negedge clk);
    #1;
    check("idle_no_writes", 32'(wa_q.size() - base_w), 32'd0);
    ok = 1'b1;
    for (int c = s_cyc; c < s_cyc + 5; c++) if (hold_log[c]) ok = 1'b0;
    check("idle_hold_low", 32'(ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream. It receives a length header and 16-bit instruction words over a valid/ready byte interface. Each word is written to consecutive even (byte-addressed) locations starting at BASE_ADDR. While loading, the block holds the pipeline so instruction fetch never sees a partially written program.

## Interface
- ADDR_W, 16, width of the instruction-memory byte address.
- BASE_ADDR, 16'h0000, byte address of the first word written.
- MAX_WORDS, 16, number of word slots in instruction memory; words beyond this are dropped.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level/pulse; sampled only in IDLE; begins a load.
- abort  in  1  terminates a load in progress; returns to IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready at a rising edge.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  write byte address (always even when BASE_ADDR is even).
- wr_data  out  16  instruction word, {hi byte, lo byte}.
- hold  out  1  stall request to PC/fetch while loading.
- done  out  1  one-cycle pulse at end of a load.
- overflow  out  1  sticky: header count exceeded MAX_WORDS; cleared on next accepted start.

## Operation
- Stream format, byte order MSB first: LEN_HI, LEN_LO (16-bit word count N), then N × (WORD_HI, WORD_LO).
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE.
- IDLE: in_ready=0, hold=0. On start=1: go to LEN_HI, set hold, clear overflow, word index=0.
- LEN_HI / LEN_LO: in_ready=1; capture count on each accepted byte. After LEN_LO: if N=0 go to DONE, else go to DATA_HI.
- DATA_HI: in_ready=1; capture the high byte.
- DATA_LO: in_ready=1; capture the low byte, then go to WRITE.
- WRITE: in_ready=0.
  - If index < MAX_WORDS: wr_en=1, wr_addr=BASE_ADDR+2·index (mod 2^ADDR_W), wr_data={hi,lo}.
  - Otherwise: wr_en=0 and overflow←1.
  - Then index+1. Go to DONE if index+1 == N, else to DATA_HI.
- DONE: in_ready=0, hold=1, done=1 for exactly one cycle, then IDLE.
- hold=1 in every state except IDLE.
- Word index and count are 16-bit; no wrap for N ≤ 65535.
- abort=1 in any non-IDLE state: next state IDLE. No wr_en in that cycle or later, no done pulse. A byte offered that cycle is not accepted (in_ready forced 0 while abort=1). overflow keeps its value.
- start while not IDLE is ignored.
- in_valid low stalls the FSM in the current receive state indefinitely; no timeout.
- wr_addr/wr_data hold their last values when wr_en=0.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, hold=0, done=0, overflow=0, state IDLE.
- rst asserted mid-load: all outputs take reset values immediately (asynchronously); the partial program is left in memory.
- Outputs are registered except in_ready, which is decoded from state and abort.
- Start accepted at edge 0: LEN_HI is entered at edge 0, and hold is high from edge 0.
- With in_valid continuously high:
  - Length bytes take 2 cycles.
  - Each word takes 3 cycles (HI, LO, WRITE).
  - wr_en is high in the cycle after the LO byte is accepted.
  - done is high 3 + 3N cycles after start is sampled.
- Back-to-back loads: start may be sampled in the cycle immediately after DONE.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately; release and idle 5 cycles → no wr_en, hold=0.
- Load 3 words (bytes 00 03 D1 04 A2 12 94 12), in_valid always high → exactly 3 wr_en pulses, writing (0000,D104), (0002,A212), (0004,9412); done 12 cycles after start; hold high from start through the done cycle.
- Count 0 (bytes 00 00) → no wr_en; done 3 cycles after start; overflow=0.
- Random in_valid gaps (about 50% duty) with the same 3-word stream → same writes and order; no byte accepted while in_ready=0.
- MAX_WORDS=4, N=6 → 4 writes at 0000–0006; overflow=1 after the 5th word; done still pulses; next start clears overflow.
- abort after WORD_HI of the 2nd word → exactly 1 write, no done, hold=0 next cycle; a new 1-word load then writes at BASE_ADDR.
